mem_bus_arb: RTL and testbench

Arbiter and tag tracker for the single processor-to-memory bus. Three requesters share the bus: instruction-cache miss loads, data-cache MSHR miss loads, and data-cache store write-throughs. The block picks one requester per cycle and drives the memory command. It records the memory response tag of each accepted load, then routes the tagged return data back to its owner (I-cache fill, or D-cache MSHR fill with address, which the LSQ matches against queued load misses).

---
 rtl/mem_bus_arb_if.sv | 49 ++++
 rtl/mem_bus_arb.sv | 125 ++++++++++++
 tb/tb_mem_bus_arb.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arb_if.sv
// Processor-to-memory bus bundle: requester handshakes, memory command/response
// and fill return. The arbiter sits on the slave side; requesters and memory on master.
interface mem_bus_arb_if #(
  parameter int TAG_W = 4
);
  logic              ic_req_i;
  logic [63:0]       ic_addr_i;
  logic              dc_ld_req_i;
  logic [63:0]       dc_ld_addr_i;
  logic              dc_st_req_i;
  logic [63:0]       dc_st_addr_i;
  logic [63:0]       dc_st_data_i;
  logic [TAG_W-1:0]  mem2proc_response_i;
  logic [63:0]       mem2proc_data_i;
  logic [TAG_W-1:0]  mem2proc_tag_i;

  logic [1:0]        proc2mem_command_o;
  logic [63:0]       proc2mem_addr_o;
  logic [63:0]       proc2mem_data_o;
  logic              ic_acc_o;
  logic              dc_ld_acc_o;
  logic              dc_st_acc_o;
  logic              ic_fill_vld_o;
  logic [63:0]       ic_fill_data_o;
  logic              dc_fill_vld_o;
  logic [63:0]       dc_fill_data_o;
  logic [63:0]       dc_fill_addr_o;
  logic [TAG_W-1:0]  out_cnt_o;

  modport slave (
    input  ic_req_i, ic_addr_i, dc_ld_req_i, dc_ld_addr_i,
           dc_st_req_i, dc_st_addr_i, dc_st_data_i,
           mem2proc_response_i, mem2proc_data_i, mem2proc_tag_i,
    output proc2mem_command_o, proc2mem_addr_o, proc2mem_data_o,
           ic_acc_o, dc_ld_acc_o, dc_st_acc_o,
           ic_fill_vld_o, ic_fill_data_o,
           dc_fill_vld_o, dc_fill_data_o, dc_fill_addr_o, out_cnt_o
  );

  modport master (
    output ic_req_i, ic_addr_i, dc_ld_req_i, dc_ld_addr_i,
           dc_st_req_i, dc_st_addr_i, dc_st_data_i,
           mem2proc_response_i, mem2proc_data_i, mem2proc_tag_i,
    input  proc2mem_command_o, proc2mem_addr_o, proc2mem_data_o,
           ic_acc_o, dc_ld_acc_o, dc_st_acc_o,
           ic_fill_vld_o, ic_fill_data_o,
           dc_fill_vld_o, dc_fill_data_o, dc_fill_addr_o, out_cnt_o
  );
endinterface

// File: rtl/mem_bus_arb.sv
// Memory bus arbiter for I-cache loads, D-cache loads and D-cache stores, with a
// tag table that routes tagged load returns back to the owning cache.
module mem_bus_arb #(
  parameter int TAG_W      = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_bus_arb_if.slave bus
);
  localparam int NUM_TAGS = 1 << TAG_W;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_STORE = 2'd2
  } cmd_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IC,
    GNT_DC_LD,
    GNT_DC_ST
  } gnt_e;

  logic [NUM_TAGS-1:0] vld_q;
  logic [NUM_TAGS-1:0] vld_next;
  logic                owner_ic_q [NUM_TAGS];
  logic [63:0]         addr_q     [NUM_TAGS];
  logic [2:0]          starve_cnt_q;
  logic [TAG_W-1:0]    out_cnt_q;

  gnt_e gnt;
  logic table_full;
  logic starving;
  logic accepted;
  logic load_acc;
  logic fill_hit;
  logic fill_owner_ic;

  // Entry 0 is never allocated, so only tags 1..NUM_TAGS-1 count toward full.
  assign table_full    = &vld_q[NUM_TAGS-1:1];
  assign starving      = int'(starve_cnt_q) >= STARVE_LIM;
  assign accepted      = (gnt != GNT_NONE) && (bus.mem2proc_response_i != '0);
  assign load_acc      = accepted && ((gnt == GNT_IC) || (gnt == GNT_DC_LD));
  assign fill_hit      = !rst && (bus.mem2proc_tag_i != '0) && vld_q[bus.mem2proc_tag_i];
  assign fill_owner_ic = owner_ic_q[bus.mem2proc_tag_i];

  // Stores stay eligible when the table is full; loads need a free tag.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (starving && bus.ic_req_i && !table_full)  gnt = GNT_IC;
      else if (bus.dc_st_req_i)                     gnt = GNT_DC_ST;
      else if (bus.dc_ld_req_i && !table_full)      gnt = GNT_DC_LD;
      else if (bus.ic_req_i && !table_full)         gnt = GNT_IC;
    end
  end

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    bus.proc2mem_command_o = CMD_NONE;
    bus.proc2mem_addr_o    = '0;
    bus.proc2mem_data_o    = '0;
    bus.ic_acc_o           = 1'b0;
    bus.dc_ld_acc_o        = 1'b0;
    bus.dc_st_acc_o        = 1'b0;
    unique case (gnt)
      GNT_IC: begin
        bus.proc2mem_command_o = CMD_LOAD;
        bus.proc2mem_addr_o    = bus.ic_addr_i;
        bus.ic_acc_o           = accepted;
      end
      GNT_DC_LD: begin
        bus.proc2mem_command_o = CMD_LOAD;
        bus.proc2mem_addr_o    = bus.dc_ld_addr_i;
        bus.dc_ld_acc_o        = accepted;
      end
      GNT_DC_ST: begin
        bus.proc2mem_command_o = CMD_STORE;
        bus.proc2mem_addr_o    = bus.dc_st_addr_i;
        bus.proc2mem_data_o    = bus.dc_st_data_i;
        bus.dc_st_acc_o        = accepted;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.ic_fill_vld_o  = fill_hit && fill_owner_ic;
    bus.dc_fill_vld_o  = fill_hit && !fill_owner_ic;
    bus.ic_fill_data_o = bus.ic_fill_vld_o ? bus.mem2proc_data_i : '0;
    bus.dc_fill_data_o = bus.dc_fill_vld_o ? bus.mem2proc_data_i : '0;
    bus.dc_fill_addr_o = bus.dc_fill_vld_o ? addr_q[bus.mem2proc_tag_i] : '0;
    bus.out_cnt_o      = rst ? '0 : out_cnt_q;
  end

  // Retire the filled entry, then allocate; a same-tag allocate overrides the clear.
  always_comb begin
    vld_next = vld_q;
    if (fill_hit) vld_next[bus.mem2proc_tag_i] = 1'b0;
    if (load_acc) vld_next[bus.mem2proc_response_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= '0;
      starve_cnt_q <= '0;
      out_cnt_q    <= '0;
    end else begin
      vld_q     <= vld_next;
      out_cnt_q <= TAG_W'($countones(vld_next));
      if (!bus.ic_req_i || bus.ic_acc_o) starve_cnt_q <= '0;
      else if (starve_cnt_q != 3'd7)     starve_cnt_q <= starve_cnt_q + 3'd1;
    end
  end

  // NOTE: owner/addr payload is not reset; vld gates every read of it.
  always_ff @(posedge clk) begin
    if (load_acc) begin
      owner_ic_q[bus.mem2proc_response_i] <= (gnt == GNT_IC);
      addr_q[bus.mem2proc_response_i]     <= (gnt == GNT_IC) ? bus.ic_addr_i : bus.dc_ld_addr_i;
    end
  end
endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed bench for mem_bus_arb: arbitration order, starvation promotion,
// tag table fill routing, full table, same-tag fill/allocate and reset drop.
module tb_mem_bus_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_arb_if #(.TAG_W(4)) bus ();

  mem_bus_arb #(.TAG_W(4), .STARVE_LIM(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.ic_req_i            = 1'b0;
    bus.ic_addr_i           = '0;
    bus.dc_ld_req_i         = 1'b0;
    bus.dc_ld_addr_i        = '0;
    bus.dc_st_req_i         = 1'b0;
    bus.dc_st_addr_i        = '0;
    bus.dc_st_data_i        = '0;
    bus.mem2proc_response_i = '0;
    bus.mem2proc_data_i     = '0;
    bus.mem2proc_tag_i      = '0;
  endtask

  // Inputs change just after the rising edge; combinational outputs are sampled at the falling edge.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    // Outputs stay quiet while reset is high, even with live requests.
    bus.ic_req_i = 1'b1;
    bus.ic_addr_i = 64'hAAAA;
    bus.mem2proc_response_i = 4'd1;
    mid();
    check("rst_cmd", 64'(bus.proc2mem_command_o), 64'd0);
    check("rst_ic_acc", 64'(bus.ic_acc_o), 64'd0);
    next();
    idle();
    rst = 1'b0;
    next();
    check("reset_out_cnt", 64'(bus.out_cnt_o), 64'd0);

    // All three request; store wins and no tag is allocated.
    bus.ic_req_i = 1'b1;      bus.ic_addr_i = 64'h100;
    bus.dc_ld_req_i = 1'b1;   bus.dc_ld_addr_i = 64'h200;
    bus.dc_st_req_i = 1'b1;   bus.dc_st_addr_i = 64'h300; bus.dc_st_data_i = 64'h5A5A;
    bus.mem2proc_response_i = 4'd3;
    mid();
    check("all3_cmd", 64'(bus.proc2mem_command_o), 64'd2);
    check("all3_addr", bus.proc2mem_addr_o, 64'h300);
    check("all3_data", bus.proc2mem_data_o, 64'h5A5A);
    check("all3_st_acc", 64'(bus.dc_st_acc_o), 64'd1);
    check("all3_ld_acc", 64'(bus.dc_ld_acc_o), 64'd0);
    check("all3_ic_acc", 64'(bus.ic_acc_o), 64'd0);
    next();
    idle();
    check("all3_out_cnt", 64'(bus.out_cnt_o), 64'd0);

    // D-cache load, tag 5, data returns two cycles after accept.
    bus.dc_ld_req_i = 1'b1; bus.dc_ld_addr_i = 64'h1000; bus.mem2proc_response_i = 4'd5;
    mid();
    check("dl_cmd", 64'(bus.proc2mem_command_o), 64'd1);
    check("dl_addr", bus.proc2mem_addr_o, 64'h1000);
    check("dl_data_zero", bus.proc2mem_data_o, 64'd0);
    check("dl_acc", 64'(bus.dc_ld_acc_o), 64'd1);
    next();
    idle();
    check("dl_out_cnt1", 64'(bus.out_cnt_o), 64'd1);
    mid();
    check("dl_no_fill_yet", 64'(bus.dc_fill_vld_o), 64'd0);
    next();
    bus.mem2proc_tag_i = 4'd5; bus.mem2proc_data_i = 64'hDEAD;
    mid();
    check("dl_fill_vld", 64'(bus.dc_fill_vld_o), 64'd1);
    check("dl_fill_data", bus.dc_fill_data_o, 64'hDEAD);
    check("dl_fill_addr", bus.dc_fill_addr_o, 64'h1000);
    check("dl_ic_fill", 64'(bus.ic_fill_vld_o), 64'd0);
    next();
    idle();
    check("dl_out_cnt0", 64'(bus.out_cnt_o), 64'd0);

    // Starvation: store and I-cache both held; I-cache wins in the 5th cycle.
    bus.dc_st_req_i = 1'b1; bus.dc_st_addr_i = 64'h3000; bus.dc_st_data_i = 64'h55;
    bus.ic_req_i = 1'b1;    bus.ic_addr_i = 64'h4000;
    bus.mem2proc_response_i = 4'd1;
    for (int c = 1; c <= 6; c++) begin
      mid();
      check($sformatf("starve_ic_acc_c%0d", c), 64'(bus.ic_acc_o), 64'(c == 5));
      check($sformatf("starve_st_acc_c%0d", c), 64'(bus.dc_st_acc_o), 64'(c != 5));
      next();
    end
    idle();
    check("starve_out_cnt", 64'(bus.out_cnt_o), 64'd1);
    bus.mem2proc_tag_i = 4'd1; bus.mem2proc_data_i = 64'hCAFE;
    mid();
    check("ic_fill_vld", 64'(bus.ic_fill_vld_o), 64'd1);
    check("ic_fill_data", bus.ic_fill_data_o, 64'hCAFE);
    check("ic_fill_dc_vld", 64'(bus.dc_fill_vld_o), 64'd0);
    next();
    idle();
    check("ic_fill_out_cnt", 64'(bus.out_cnt_o), 64'd0);

    // Fill all 15 tags with D-cache loads.
    for (int i = 1; i <= 15; i++) begin
      bus.dc_ld_req_i = 1'b1;
      bus.dc_ld_addr_i = 64'h2000 + 64'(i) * 64'h40;
      bus.mem2proc_response_i = 4'(i);
      mid();
      check($sformatf("fill_acc_t%0d", i), 64'(bus.dc_ld_acc_o), 64'd1);
      next();
    end
    idle();
    check("full_out_cnt", 64'(bus.out_cnt_o), 64'd15);
    bus.dc_ld_req_i = 1'b1; bus.dc_ld_addr_i = 64'h9000;
    bus.ic_req_i = 1'b1;    bus.ic_addr_i = 64'h9100;
    bus.mem2proc_response_i = 4'd2;
    mid();
    check("full_cmd_none", 64'(bus.proc2mem_command_o), 64'd0);
    check("full_ld_acc", 64'(bus.dc_ld_acc_o), 64'd0);
    check("full_ic_acc", 64'(bus.ic_acc_o), 64'd0);
    check("full_addr_zero", bus.proc2mem_addr_o, 64'd0);
    bus.dc_st_req_i = 1'b1; bus.dc_st_addr_i = 64'h9200; bus.dc_st_data_i = 64'h77;
    mid();
    next();
    // Same cycle as above is past; re-sample with the store present.
    mid();
    check("full_st_cmd", 64'(bus.proc2mem_command_o), 64'd2);
    check("full_st_acc", 64'(bus.dc_st_acc_o), 64'd1);
    check("full_st_ld_acc", 64'(bus.dc_ld_acc_o), 64'd0);
    next();
    idle();
    check("full_after_st_cnt", 64'(bus.out_cnt_o), 64'd15);

    // Free tag 3 so a new load can be accepted.
    bus.mem2proc_tag_i = 4'd3; bus.mem2proc_data_i = 64'h33;
    mid();
    check("t3_fill_addr", bus.dc_fill_addr_o, 64'h20C0);
    next();
    idle();
    check("t3_out_cnt", 64'(bus.out_cnt_o), 64'd14);

    // Tag 7 returns to its old D-cache owner while an I-cache load takes tag 7.
    bus.ic_req_i = 1'b1; bus.ic_addr_i = 64'h7000; bus.mem2proc_response_i = 4'd7;
    bus.mem2proc_tag_i = 4'd7; bus.mem2proc_data_i = 64'hBEEF;
    mid();
    check("same_ic_acc", 64'(bus.ic_acc_o), 64'd1);
    check("same_dc_fill", 64'(bus.dc_fill_vld_o), 64'd1);
    check("same_dc_data", bus.dc_fill_data_o, 64'hBEEF);
    check("same_dc_addr", bus.dc_fill_addr_o, 64'h21C0);
    check("same_ic_fill", 64'(bus.ic_fill_vld_o), 64'd0);
    next();
    idle();
    check("same_out_cnt", 64'(bus.out_cnt_o), 64'd14);
    bus.mem2proc_tag_i = 4'd7; bus.mem2proc_data_i = 64'h1234;
    mid();
    check("t7_ic_fill", 64'(bus.ic_fill_vld_o), 64'd1);
    check("t7_ic_data", bus.ic_fill_data_o, 64'h1234);
    check("t7_dc_fill", 64'(bus.dc_fill_vld_o), 64'd0);
    next();
    idle();
    check("t7_out_cnt", 64'(bus.out_cnt_o), 64'd13);

    // Tag 9 returns once (valid), then again on an invalid entry.
    bus.mem2proc_tag_i = 4'd9; bus.mem2proc_data_i = 64'h99;
    mid();
    check("t9_first_fill", 64'(bus.dc_fill_vld_o), 64'd1);
    next();
    check("t9_out_cnt", 64'(bus.out_cnt_o), 64'd12);
    mid();
    check("t9_dup_dc_fill", 64'(bus.dc_fill_vld_o), 64'd0);
    check("t9_dup_ic_fill", 64'(bus.ic_fill_vld_o), 64'd0);
    next();
    idle();
    check("t9_dup_out_cnt", 64'(bus.out_cnt_o), 64'd12);

    // Mid-operation reset drops all outstanding tags.
    rst = 1'b1;
    bus.mem2proc_tag_i = 4'd1; bus.mem2proc_data_i = 64'h11;
    mid();
    check("rst_mid_fill", 64'(bus.dc_fill_vld_o), 64'd0);
    next();
    rst = 1'b0;
    idle();
    check("rst_mid_out_cnt", 64'(bus.out_cnt_o), 64'd0);
    for (int k = 0; k < 3; k++) begin
      bus.mem2proc_tag_i = 4'(k + 1); bus.mem2proc_data_i = 64'hF0 + 64'(k);
      mid();
      check($sformatf("post_rst_dc_fill_t%0d", k + 1), 64'(bus.dc_fill_vld_o), 64'd0);
      check($sformatf("post_rst_ic_fill_t%0d", k + 1), 64'(bus.ic_fill_vld_o), 64'd0);
      next();
    end
    idle();
    check("post_rst_out_cnt", 64'(bus.out_cnt_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
